// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier: retires two multiplier bits per clock over W/2+1 steps,
// signed or unsigned operands per operation, start/done handshake with a registered product.
module booth_radix4_seq_mult #(
  parameter int Word_Length = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [Word_Length-1:0]     multiplicand,
  input  logic [Word_Length-1:0]     multiplier,
  output logic                       busy,
  output logic                       done,
  output logic [2*Word_Length-1:0]   product
);
  localparam int W     = Word_Length;
  localparam int X     = W + 2;
  localparam int STEPS = X / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(STEPS - 1);
  localparam logic [2*X-1:0] ACC_ONE  = {{(2*X-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_next_state;
  logic [CW-1:0]     r_cnt;
  logic [2*X-1:0]    r_acc;
  logic [2*X-1:0]    r_mcand;
  logic [X-1:0]      r_mplier;
  logic              r_qm1;
  logic [2*W-1:0]    r_product;

  logic              w_load;
  logic              w_last;
  logic [2*X-1:0]    w_a_ext;
  logic [X-1:0]      w_b_ext;
  logic [2*X-1:0]    w_addend;
  logic [2*X-1:0]    w_acc_next;

  assign w_a_ext = signed_mode ? {{(2*X-W){multiplicand[W-1]}}, multiplicand}
                               : {{(2*X-W){1'b0}}, multiplicand};
  assign w_b_ext = signed_mode ? {{(X-W){multiplier[W-1]}}, multiplier}
                               : {{(X-W){1'b0}}, multiplier};

  // r_mcand is pre-shifted by 2i each step, so the digit only ever selects 0, +-A or +-2A.
  always_comb begin
    w_addend = '0;
    case ({r_mplier[1:0], r_qm1})
      3'b001, 3'b010: w_addend = r_mcand;
      3'b011:         w_addend = r_mcand << 1;
      3'b100:         w_addend = ~(r_mcand << 1) + ACC_ONE;
      3'b101, 3'b110: w_addend = ~r_mcand + ACC_ONE;
      default:        w_addend = '0;
    endcase
  end

  assign w_acc_next = r_acc + w_addend;
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_load     = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_CALC;
      S_CALC:  if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_CALC : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_qm1     <= 1'b0;
      r_product <= '0;
    end else if (w_load) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= w_a_ext;
      r_mplier  <= w_b_ext;
      r_qm1     <= 1'b0;
    end else if (r_state == S_CALC) begin
      r_acc     <= w_acc_next;
      r_mcand   <= r_mcand << 2;
      r_mplier  <= r_mplier >> 2;
      r_qm1     <= r_mplier[1];
      r_cnt     <= r_cnt + 1'b1;
      if (w_last) r_product <= w_acc_next[2*W-1:0];
    end
  end

  assign busy    = (r_state == S_CALC);
  assign done    = (r_state == S_DONE);
  assign product = r_product;
endmodule
